// File: rtl/multicycle_pkg.sv
// multicycle_pkg: shared opcodes, state encodings, ALU classes and mux selects for the multicycle controller
package multicycle_pkg;
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_JAL    = 4'd10
  } state_e;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BLTZ  = 6'b000001;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_BLE   = 6'b000110;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [2:0] ALU_RTYPE = 3'b000;
  localparam logic [2:0] ALU_ADD   = 3'b001;
  localparam logic [2:0] ALU_SLT   = 3'b010;
  localparam logic [2:0] ALU_BEQ   = 3'b011;
  localparam logic [2:0] ALU_LUI   = 3'b100;
  localparam logic [2:0] ALU_ORI   = 3'b101;
  localparam logic [2:0] ALU_BNE   = 3'b110;
  localparam logic [2:0] ALU_BLE   = 3'b111;
  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] DST_RT    = 2'b00;
  localparam logic [1:0] DST_RD    = 2'b01;
  localparam logic [1:0] DST_R31   = 2'b10;
  localparam logic [1:0] WB_ALUOUT = 2'b00;
  localparam logic [1:0] WB_MDR    = 2'b01;
  localparam logic [1:0] WB_PC     = 2'b10;
  localparam logic [1:0] B_RT      = 2'b00;
  localparam logic [1:0] B_FOUR    = 2'b01;
  localparam logic [1:0] B_IMM     = 2'b10;
  localparam logic [1:0] B_IMM_SH  = 2'b11;
  function automatic state_e decode_next(input logic [5:0] op);
    return op inside {OP_LW, OP_SW} ? S_MEMADR :
           op inside {OP_RTYPE, OP_ADDI, OP_SLTIU, OP_LUI, OP_ORI} ? S_EXEC :
           op inside {OP_BEQ, OP_BNE, OP_BLE, OP_BLTZ} ? S_BRANCH :
           op == OP_J ? S_JUMP :
           op == OP_JAL ? S_JAL : S_FETCH;
  endfunction
  function automatic logic [2:0] alu_op_for(input logic [5:0] op);
    case (op)
      OP_RTYPE:         return ALU_RTYPE;
      OP_SLTIU, OP_BLTZ: return ALU_SLT;
      OP_LUI:           return ALU_LUI;
      OP_ORI:           return ALU_ORI;
      OP_BEQ:           return ALU_BEQ;
      OP_BNE:           return ALU_BNE;
      OP_BLE:           return ALU_BLE;
      default:          return ALU_ADD;
    endcase
  endfunction
endpackage

// File: rtl/multicycle_ctrl_out.sv
// multicycle_ctrl_out: combinational map from (state, opcode, mem_ready) to datapath control signals
module multicycle_ctrl_out
  import multicycle_pkg::*;
(
  input  state_e     state_i,
  input  logic [5:0] op_i,
  input  logic       mem_ready_i,
  output logic       pc_write_o,
  output logic       pc_write_cond_o,
  output logic [1:0] pc_src_o,
  output logic       i_or_d_o,
  output logic       ir_write_o,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       reg_write_o,
  output logic [1:0] reg_dst_o,
  output logic [1:0] mem_to_reg_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [2:0] alu_op_o,
  output logic       set_zero_o,
  output logic       illegal_o
);
  always_comb begin
    pc_write_o      = 1'b0;
    pc_write_cond_o = 1'b0;
    pc_src_o        = PC_ALU;
    i_or_d_o        = 1'b0;
    ir_write_o      = 1'b0;
    mem_read_o      = 1'b0;
    mem_write_o     = 1'b0;
    reg_write_o     = 1'b0;
    reg_dst_o       = DST_RT;
    mem_to_reg_o    = WB_ALUOUT;
    alu_src_a_o     = 1'b0;
    alu_src_b_o     = B_RT;
    alu_op_o        = ALU_RTYPE;
    set_zero_o      = 1'b0;
    illegal_o       = 1'b0;
    case (state_i)
      S_FETCH: begin
        mem_read_o  = 1'b1;
        alu_src_b_o = B_FOUR;
        alu_op_o    = ALU_ADD;
        ir_write_o  = mem_ready_i;
        pc_write_o  = mem_ready_i;
      end
      S_DECODE: begin
        alu_src_b_o = B_IMM_SH;
        alu_op_o    = ALU_ADD;
        illegal_o   = decode_next(op_i) == S_FETCH;
      end
      S_MEMADR: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = B_IMM;
        alu_op_o    = ALU_ADD;
      end
      S_MEMRD: begin
        mem_read_o = 1'b1;
        i_or_d_o   = 1'b1;
      end
      S_MEMWB: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = WB_MDR;
      end
      S_MEMWR: begin
        mem_write_o = 1'b1;
        i_or_d_o    = 1'b1;
      end
      S_EXEC: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = op_i == OP_RTYPE ? B_RT : B_IMM;
        alu_op_o    = alu_op_for(op_i);
      end
      S_ALUWB: begin
        reg_write_o = 1'b1;
        reg_dst_o   = op_i == OP_RTYPE ? DST_RD : DST_RT;
      end
      S_BRANCH: begin
        pc_write_cond_o = 1'b1;
        pc_src_o        = PC_ALUOUT;
        alu_src_a_o     = 1'b1;
        alu_op_o        = alu_op_for(op_i);
        set_zero_o      = op_i == OP_BLTZ;
      end
      S_JUMP: begin
        pc_write_o = 1'b1;
        pc_src_o   = PC_JUMP;
      end
      S_JAL: begin
        pc_write_o   = 1'b1;
        pc_src_o     = PC_JUMP;
        reg_write_o  = 1'b1;
        reg_dst_o    = DST_R31;
        mem_to_reg_o = WB_PC;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multicycle MIPS-style control FSM with latched opcode and reset-gated write strobes
module multicycle_ctrl
  import multicycle_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [5:0] instr_op_i,
  input  logic       mem_ready_i,
  output logic       pc_write_o,
  output logic       pc_write_cond_o,
  output logic [1:0] pc_src_o,
  output logic       i_or_d_o,
  output logic       ir_write_o,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       reg_write_o,
  output logic [1:0] reg_dst_o,
  output logic [1:0] mem_to_reg_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [2:0] alu_op_o,
  output logic       set_zero_o,
  output logic       illegal_o,
  output logic [3:0] state_o
);
  state_e state_q, state_d;
  logic [5:0] op_q, op_d;
  logic pc_write, pc_write_cond, ir_write, mem_write, reg_write, illegal;
  always_comb begin
    op_d    = state_q == S_DECODE ? instr_op_i : op_q;
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = mem_ready_i ? S_DECODE : S_FETCH;
      S_DECODE: state_d = decode_next(instr_op_i);
      S_MEMADR: state_d = op_q == OP_LW ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = mem_ready_i ? S_MEMWB : S_MEMRD;
      S_MEMWR:  state_d = mem_ready_i ? S_FETCH : S_MEMWR;
      S_EXEC:   state_d = S_ALUWB;
      default:  state_d = S_FETCH;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_FETCH;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end
  multicycle_ctrl_out u_out (
    .state_i         (state_q),
    .op_i            (op_d),
    .mem_ready_i     (mem_ready_i),
    .pc_write_o      (pc_write),
    .pc_write_cond_o (pc_write_cond),
    .pc_src_o        (pc_src_o),
    .i_or_d_o        (i_or_d_o),
    .ir_write_o      (ir_write),
    .mem_read_o      (mem_read_o),
    .mem_write_o     (mem_write),
    .reg_write_o     (reg_write),
    .reg_dst_o       (reg_dst_o),
    .mem_to_reg_o    (mem_to_reg_o),
    .alu_src_a_o     (alu_src_a_o),
    .alu_src_b_o     (alu_src_b_o),
    .alu_op_o        (alu_op_o),
    .set_zero_o      (set_zero_o),
    .illegal_o       (illegal)
  );
  assign pc_write_o      = pc_write & ~rst_i;
  assign pc_write_cond_o = pc_write_cond & ~rst_i;
  assign ir_write_o      = ir_write & ~rst_i;
  assign mem_write_o     = mem_write & ~rst_i;
  assign reg_write_o     = reg_write & ~rst_i;
  assign illegal_o       = illegal & ~rst_i;
  assign state_o         = state_q;
endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have one clock and one reset: reset is synchronous and active-high.
REQ-002 SHALL provide `clk_i`, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL provide `rst_i`, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL provide `instr_op_i`, input, 6 bits: opcode field of the instruction register.
REQ-005 SHALL provide `mem_ready_i`, input, 1 bit: memory completes the current access this cycle.
REQ-006 SHALL provide `pc_write_o`, output, 1 bit: unconditional PC load.
REQ-007 SHALL provide `pc_write_cond_o`, output, 1 bit: PC load if the datapath branch condition is true.
REQ-008 SHALL provide `pc_src_o`, output, 2 bits: PC source. 00 = ALU result (PC+4); 01 = ALUOut (branch target); 10 = jump target.
REQ-009 SHALL provide `i_or_d_o`, output, 1 bit: memory address source. 0 = PC; 1 = ALUOut.
REQ-010 SHALL provide `ir_write_o`, output, 1 bit: instruction register load.
REQ-011 SHALL provide `mem_read_o` and `mem_write_o`, outputs, 1 bit each: memory access requests.
REQ-012 SHALL provide `reg_write_o`, output, 1 bit: register-file write.
REQ-013 SHALL provide `reg_dst_o`, output, 2 bits: destination register. 00 = rt; 01 = rd; 10 = $31.
REQ-014 SHALL provide `mem_to_reg_o`, output, 2 bits: write-back data. 00 = ALUOut; 01 = MDR; 10 = PC.
REQ-015 SHALL provide `alu_src_a_o`, output, 1 bit: ALU A input. 0 = PC; 1 = rs.
REQ-016 SHALL provide `alu_src_b_o`, output, 2 bits: ALU B input. 00 = rt; 01 = constant 4; 10 = sign-extended immediate; 11 = sign-extended immediate << 2.
REQ-017 SHALL provide `alu_op_o`, output, 3 bits: ALU operation class. 000 R-type, 001 add, 010 sltiu/slt, 011 beq, 100 lui, 101 ori, 110 bne, 111 ble.
REQ-018 SHALL provide `set_zero_o`, output, 1 bit: branch tests the sign of the result (bltz).
REQ-019 SHALL provide `illegal_o`, output, 1 bit: one-cycle pulse on an unsupported opcode.
REQ-020 SHALL provide `state_o`, output, 4 bits: current state, for debug.

Function
REQ-021 SHALL implement a registered Moore FSM with these states: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JUMP=9, JAL=10.
REQ-022 SHALL drive every output not listed for the current state to 0.
REQ-023 In FETCH: `mem_read_o`=1, `i_or_d_o`=0, `alu_src_a_o`=0, `alu_src_b_o`=01, `alu_op_o`=001, `pc_src_o`=00.
REQ-024 In FETCH: `ir_write_o`=1 and `pc_write_o`=1 only in the cycle where `mem_ready_i`=1. The FSM stays in FETCH while `mem_ready_i`=0.
REQ-025 In DECODE: latch `instr_op_i` into an internal opcode register; drive `alu_src_a_o`=0, `alu_src_b_o`=11, `alu_op_o`=001 (branch target into ALUOut).
REQ-026 Next state from DECODE: lw/sw go to MEMADR; R-type, addi, sltiu, lui and ori go to EXEC; beq, bne, ble and bltz go to BRANCH; j goes to JUMP; jal goes to JAL.
REQ-027 An opcode outside that set SHALL pulse `illegal_o` for one cycle in DECODE, then return to FETCH with no register or memory write.
REQ-028 In MEMADR: `alu_src_a_o`=1, `alu_src_b_o`=10, `alu_op_o`=001. Next state is MEMRD for lw, MEMWR for sw.
REQ-029 In MEMRD: `mem_read_o`=1, `i_or_d_o`=1. Hold in MEMRD until `mem_ready_i`=1, then go to MEMWB.
REQ-030 In MEMWB: `reg_write_o`=1, `reg_dst_o`=00, `mem_to_reg_o`=01. Next state is FETCH.
REQ-031 In MEMWR: `mem_write_o`=1, `i_or_d_o`=1. Hold in MEMWR until `mem_ready_i`=1, then go to FETCH.
REQ-032 In EXEC: `alu_src_a_o`=1; `alu_src_b_o`=00 for R-type, 10 otherwise; `alu_op_o` per REQ-017 from the latched opcode (addi uses 001). Next state is ALUWB.
REQ-033 In ALUWB: `reg_write_o`=1, `mem_to_reg_o`=00; `reg_dst_o`=01 for R-type, 00 otherwise. Next state is FETCH.
REQ-034 In BRANCH: `pc_write_cond_o`=1, `pc_src_o`=01, `alu_src_a_o`=1, `alu_src_b_o`=00, `alu_op_o` per opcode (bltz: 010 with `set_zero_o`=1). Next state is FETCH.
REQ-035 In JUMP: `pc_write_o`=1, `pc_src_o`=10. Next state is FETCH.
REQ-036 In JAL: `pc_write_o`=1, `pc_src_o`=10, `reg_write_o`=1, `reg_dst_o`=10, `mem_to_reg_o`=10. Next state is FETCH.
REQ-037 With zero-wait memory, instruction latency SHALL be: lw 5 cycles; R-type, I-type ALU and sw 4 cycles; branch, j and jal 3 cycles. Each wait cycle (`mem_ready_i`=0) adds exactly one cycle.
REQ-038 A change on `instr_op_i` after DECODE SHALL NOT affect the in-flight instruction.

Reset
REQ-039 While `rst_i`=1 at a rising edge, the next state SHALL be FETCH and the opcode register SHALL be cleared to 0, including when reset arrives in the middle of an instruction or a memory wait.
REQ-040 While `rst_i`=1, `pc_write_o`, `pc_write_cond_o`, `ir_write_o`, `reg_write_o`, `mem_write_o` and `illegal_o` SHALL be forced to 0.

Structure
REQ-041 SHALL place the opcode constants, state encodings, `alu_op_o` encodings and mux-select encodings in a shared package named `multicycle_pkg`.
REQ-042 SHALL split the design into the state/opcode registers plus next-state logic in `multicycle_ctrl`, and one combinational sub-module `multicycle_ctrl_out` mapping (state, opcode, `mem_ready_i`) to the outputs.

Verification
REQ-043 Reset, then lw (opcode 100011) with `mem_ready_i`=1 -> states 0,1,2,3,4,0; `reg_write_o`=1 with `mem_to_reg_o`=01 exactly in cycle 5.
REQ-044 sw (opcode 101011) with `mem_ready_i` low for 3 cycles in MEMWR -> `mem_write_o` high for 4 cycles; FETCH entered after the ready cycle; 7 cycles total.
REQ-045 jal (opcode 000011) -> cycle 3 shows `pc_write_o`=1, `reg_dst_o`=10, `mem_to_reg_o`=10, `reg_write_o`=1.
REQ-046 Opcode 111111 -> `illegal_o`=1 for one cycle in DECODE, no write strobes asserted, FETCH on cycle 3.
REQ-047 `rst_i` asserted during MEMRD wait -> next cycle `state_o`=0; `mem_read_o` comes only from FETCH; no `reg_write_o` pulse.
REQ-048 bne (opcode 000101), then `instr_op_i` changed to 000000 during BRANCH -> `alu_op_o`=110 and `pc_write_cond_o`=1 in cycle 3.
